expr_sequencer: RTL and testbench

Programmable control sequencer for the expression-solver datapath. It generalises the fixed hard-wired control FSM into a writable microcode table of NSTEPS control words. Each word drives NLOAD register-load enables, NMUX mux selects and the ALU op bit. It adds a start/busy/done handshake, stall, abort, a proper return to idle and, optionally, multi-pass iteration.

---
 rtl/expr_sequencer.sv | 138 +++++++++++++
 tb/tb_expr_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_sequencer.sv
// Microcode-driven control sequencer for the expression-solver datapath.
// Define SEQ_LOOP_EN to compile in multi-pass iteration driven by iter.
module expr_sequencer #(
  parameter  int NSTEPS = 8,
  parameter  int NLOAD  = 3,
  parameter  int NMUX   = 3,
  parameter  int MUXW   = 2,
  localparam int SW     = $clog2(NSTEPS),
  localparam int CW_W   = NLOAD + NMUX*MUXW + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 abort,
  input  logic [7:0]           iter,
  input  logic                 prog_we,
  input  logic [SW-1:0]        prog_addr,
  input  logic [CW_W-1:0]      prog_data,
  output logic [NLOAD-1:0]     ld,
  output logic [NMUX*MUXW-1:0] msel,
  output logic                 op,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   step, step_n;
  logic [SW-1:0]   nxt;
  logic [CW_W-1:0] cw, cw_n;
  logic [CW_W-1:0] tbl [NSTEPS];
  logic            we;
  logic            pass_end;

`ifdef SEQ_LOOP_EN
  logic [7:0] pass, pass_n;
`else
  logic unused_iter;
  assign unused_iter = ^iter;
`endif

  assign nxt = step + SW'(1);

  always_comb begin
    state_n  = state;
    step_n   = step;
    cw_n     = cw;
    we       = 1'b0;
    pass_end = 1'b0;
`ifdef SEQ_LOOP_EN
    pass_n   = pass;
`endif
    unique case (state)
      IDLE: begin
        we = prog_we &&
             ({1'b0, prog_addr} < (SW+1)'(NSTEPS));
        if (start) begin
          state_n = RUN;
          step_n  = '0;
          cw_n    = tbl[0];
`ifdef SEQ_LOOP_EN
          pass_n  = (iter == 8'd0) ? 8'd1 : iter;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          step_n  = '0;
          cw_n    = '0;
        end else if (!stall) begin
          pass_end = cw[0] ||
                     (step == SW'(NSTEPS-1));
          if (!pass_end) begin
            step_n = nxt;
            cw_n   = tbl[nxt];
          end
`ifdef SEQ_LOOP_EN
          else if (pass > 8'd1) begin
            // rewind with no bubble between passes
            step_n = '0;
            cw_n   = tbl[0];
            pass_n = pass - 8'd1;
          end
`endif
          else begin
            state_n = DONE;
            step_n  = '0;
            cw_n    = '0;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      cw    <= '0;
`ifdef SEQ_LOOP_EN
      pass  <= '0;
`endif
    end else begin
      state <= state_n;
      step  <= step_n;
      cw    <= cw_n;
`ifdef SEQ_LOOP_EN
      pass  <= pass_n;
`endif
    end
  end

  // word[0] is fetched combinationally, so a same-edge write issues old data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTEPS; i++)
        tbl[i] <= '0;
    end else if (we) begin
      tbl[prog_addr] <= prog_data;
    end
  end

  assign ld   = stall ? '0 : cw[CW_W-1 -: NLOAD];
  assign msel = cw[NMUX*MUXW+1:2];
  assign op   = cw[1];
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_expr_sequencer.sv
// Self-checking bench for expr_sequencer: vector table plus
// per-cycle scoreboard of expected ld/msel/op/busy/done.
module tb_expr_sequencer;

  localparam int NSTEPS = 8;
  localparam int SW     = 3;
  localparam int CW     = 11;
`ifdef SEQ_LOOP_EN
  localparam int NP3 = 3;
`else
  localparam int NP3 = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stall, abort, prog_we;
  logic [7:0]    iter;
  logic [SW-1:0] prog_addr;
  logic [CW-1:0] prog_data;
  logic [2:0]    ld;
  logic [5:0]    msel;
  logic          op, busy, done;

  always #5 clk = ~clk;

  expr_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .stall(stall), .abort(abort), .iter(iter),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .ld(ld), .msel(msel),
    .op(op), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [2:0] ld;
    logic [5:0] msel;
    logic       op;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic [2:0] ld;
    logic [5:0] msel;
    logic       op;
    logic       last;
  } vec_t;

  exp_t          q[$];
  int            ncmp = 0;
  int            nbad = 0;
  string         tname;
  logic [CW-1:0] tbw [NSTEPS];
  vec_t          vt [7];
  logic [CW-1:0] oldw, neww;

  function automatic logic [CW-1:0] vw(input vec_t v);
    return {v.ld, v.msel, v.op, v.last};
  endfunction

  function automatic exp_t ew(input logic [CW-1:0] w, input bit m);
    exp_t e;
    e.ld   = m ? 3'b000 : w[10:8];
    e.msel = w[7:2];
    e.op   = w[1];
    e.busy = 1'b1;
    e.done = 1'b0;
    return e;
  endfunction

  function automatic exp_t edone();
    exp_t e;
    e      = '0;
    e.done = 1'b1;
    return e;
  endfunction

  task automatic cmp();
    exp_t e, g;
    if (q.size() == 0) return;
    e = q.pop_front();
    g = {ld, msel, op, busy, done};
    ncmp++;
    if (g !== e) begin
      nbad++;
      $display("FAIL %s: got ld=%b msel=%b op=%b busy=%b done=%b want ld=%b msel=%b op=%b busy=%b done=%b",
               tname, g.ld, g.msel, g.op, g.busy, g.done,
               e.ld, e.msel, e.op, e.busy, e.done);
    end
  endtask

  task automatic step(input bit s, input bit st, input bit ab,
                      input bit we, input logic [SW-1:0] a,
                      input logic [CW-1:0] d);
    @(posedge clk);
    #1;
    start     = s;
    stall     = st;
    abort     = ab;
    prog_we   = we;
    prog_addr = a;
    prog_data = d;
    #1;
    cmp();
  endtask

  task automatic go(input bit s);
    step(s, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic prog(input int a, input logic [CW-1:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, SW'(a), d);
    tbw[a] = d;
  endtask

  task automatic run(input int k, input int np,
                     input bit pre, input bit nxt);
    if (!pre) begin
      q.push_back('0);
      go(1'b1);
    end
    for (int j = 0; j < k*np; j++)
      q.push_back(ew(tbw[j % k], 1'b0));
    q.push_back(edone());
    q.push_back('0);
    repeat (k*np + 1) go(1'b0);
    go(nxt);
  endtask

  initial begin
    vt[0] = '{3'b001, 6'b000001, 1'b0, 1'b0};
    vt[1] = '{3'b010, 6'b000110, 1'b1, 1'b0};
    vt[2] = '{3'b100, 6'b011000, 1'b0, 1'b0};
    vt[3] = '{3'b011, 6'b100100, 1'b1, 1'b0};
    vt[4] = '{3'b110, 6'b010010, 1'b0, 1'b0};
    vt[5] = '{3'b101, 6'b111001, 1'b1, 1'b0};
    vt[6] = '{3'b111, 6'b001111, 1'b0, 1'b1};
    for (int i = 0; i < NSTEPS; i++) tbw[i] = '0;

    rst = 1'b1; start = 0; stall = 0; abort = 0;
    prog_we = 0; prog_addr = '0; prog_data = '0;
    iter = 8'd1;
    #12 rst = 1'b0;

    tname = "reset";
    q.push_back('0);
    go(1'b0);

    tname = "zero_run";
    run(NSTEPS, 1, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) prog(i, vw(vt[i]));
    prog(7, 11'h2a8);

    tname = "solver";
    run(7, 1, 1'b0, 1'b1);
    tname = "back2back";
    run(7, 1, 1'b1, 1'b0);

    tname = "stall";
    q.push_back('0);
    q.push_back(ew(tbw[0], 1'b0));
    q.push_back(ew(tbw[1], 1'b0));
    repeat (3) q.push_back(ew(tbw[2], 1'b1));
    for (int j = 2; j < 7; j++) q.push_back(ew(tbw[j], 1'b0));
    q.push_back(edone());
    q.push_back('0);
    go(1'b1);
    go(1'b0); go(1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    repeat (7) go(1'b0);

    tname = "abort";
    q.push_back('0);
    for (int j = 0; j < 5; j++) q.push_back(ew(tbw[j], 1'b0));
    repeat (4) q.push_back('0);
    go(1'b1);
    repeat (4) go(1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    repeat (4) go(1'b0);
    tname = "restart";
    run(7, 1, 1'b0, 1'b0);

    tname = "busy_ignore";
    q.push_back('0);
    for (int j = 0; j < 7; j++) q.push_back(ew(tbw[j], 1'b0));
    q.push_back(edone());
    q.push_back('0);
    go(1'b1);
    go(1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 11'h7ff);
    repeat (4) go(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    go(1'b0);
    tname = "tbl_kept";
    run(7, 1, 1'b0, 1'b0);

    tname = "we_start_same";
    oldw = tbw[0];
    neww = 11'h0f4;
    q.push_back('0);
    for (int j = 0; j < 7; j++) q.push_back(ew(tbw[j], 1'b0));
    q.push_back(edone());
    q.push_back('0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, neww);
    repeat (9) go(1'b0);
    tbw[0] = neww;
    tname = "new_w0";
    run(7, 1, 1'b0, 1'b0);
    prog(0, oldw);

    tname = "loop_iter3";
    prog(3, {vt[3].ld, vt[3].msel, vt[3].op, 1'b1});
    iter = 8'd3;
    run(4, NP3, 1'b0, 1'b0);
    tname = "loop_iter0";
    iter = 8'd0;
    run(4, 1, 1'b0, 1'b0);
    iter = 8'd1;

    tname = "rst_mid";
    q.push_back('0);
    q.push_back(ew(tbw[0], 1'b0));
    q.push_back(ew(tbw[1], 1'b0));
    go(1'b1); go(1'b0); go(1'b0);
    #2 rst = 1'b1;
    #1;
    q.push_back('0);
    cmp();
    #1 rst = 1'b0;
    for (int i = 0; i < NSTEPS; i++) tbw[i] = '0;
    tname = "cleared_run";
    run(NSTEPS, 1, 1'b0, 1'b0);

    if (q.size() != 0) begin
      nbad++;
      $display("FAIL leftover: got %0d queued want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
